// File: rtl/norm_arbiter_pkg.sv
// norm_arbiter_pkg: widths, source IDs and payload structs shared by the normalization arbiter.
package norm_arbiter_pkg;
  localparam int EXP_W = 10;
  localparam int FRAC_IN_W = 75;
  localparam int FRAC_OUT_W = 27;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  typedef struct packed {
    logic s;
    logic final_m;
    logic h_s;
    logic [EXP_W-1:0] exp;
    logic [FRAC_IN_W-1:0] frac;
  } op_t;
  typedef struct packed {
    logic s;
    logic [EXP_W-1:0] exp;
    logic [FRAC_OUT_W-1:0] frac;
    logic zero;
    logic denorm;
  } res_t;
endpackage

// File: rtl/norm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ptr points at the requester favoured on the next contention.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic ptr_q, ptr_d, sel_b;
  always_comb begin
    sel_b = req_b & (!req_a | ptr_q);
    gnt_a = en & !sel_b;
    gnt_b = en & sel_b;
    ptr_d = (en & req_a & req_b) ? !ptr_q : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/norm_arbiter.sv
// norm_arbiter: round-robin sharing of one combinational normalization datapath between two requesters,
// with an issue register feeding the datapath and a tagged, backpressured result register.
module norm_arbiter
  import norm_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_s,
  input  logic                  a_final_m,
  input  logic                  a_h_s,
  input  logic [EXP_W-1:0]      a_exp,
  input  logic [FRAC_IN_W-1:0]  a_frac,
  input  logic [TAG_W-1:0]      a_tag,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_s,
  input  logic                  b_final_m,
  input  logic                  b_h_s,
  input  logic [EXP_W-1:0]      b_exp,
  input  logic [FRAC_IN_W-1:0]  b_frac,
  input  logic [TAG_W-1:0]      b_tag,
  output logic                  n_s,
  output logic                  n_final_m,
  output logic                  n_h_s,
  output logic [EXP_W-1:0]      n_exp,
  output logic [FRAC_IN_W-1:0]  n_frac,
  input  logic                  n_s_final,
  input  logic [EXP_W-1:0]      n_exp_norm,
  input  logic [FRAC_OUT_W-1:0] n_frac_norm,
  input  logic                  n_zero_m,
  input  logic                  n_denorm_m,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_src,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_s,
  output logic [EXP_W-1:0]      res_exp,
  output logic [FRAC_OUT_W-1:0] res_frac,
  output logic                  res_zero,
  output logic                  res_denorm,
  output logic                  busy
);
  logic iss_v_q, iss_v_d, iss_src_q, iss_src_d, res_valid_q, res_valid_d, res_src_q, res_src_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d, res_tag_q, res_tag_d;
  op_t iss_op_q, iss_op_d;
  res_t res_q, res_d;
  logic res_en, iss_en, acc_a, acc_b, acc, ld;
  assign res_en = !res_valid_q | res_ready;
  assign iss_en = !iss_v_q | res_en;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (iss_en & !flush & !rst),
    .req_a(a_valid),
    .req_b(b_valid),
    .gnt_a(a_ready),
    .gnt_b(b_ready)
  );
  always_comb begin
    acc_a = a_ready & a_valid;
    acc_b = b_ready & b_valid;
    acc = acc_a | acc_b;
    ld = res_en & !flush;
    iss_v_d = flush ? 1'b0 : acc ? 1'b1 : res_en ? 1'b0 : iss_v_q;
    iss_src_d = acc ? (acc_b ? SRC_B : SRC_A) : iss_src_q;
    iss_tag_d = acc ? (acc_b ? b_tag : a_tag) : iss_tag_q;
    iss_op_d = acc ? (acc_b ? {b_s, b_final_m, b_h_s, b_exp, b_frac}
                            : {a_s, a_final_m, a_h_s, a_exp, a_frac}) : iss_op_q;
    res_valid_d = flush ? 1'b0 : res_en ? iss_v_q : res_valid_q;
    res_src_d = ld ? iss_src_q : res_src_q;
    res_tag_d = ld ? iss_tag_q : res_tag_q;
    res_d = ld ? {n_s_final, n_exp_norm, n_frac_norm, n_zero_m, n_denorm_m} : res_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q <= 1'b0;
      iss_src_q <= 1'b0;
      iss_tag_q <= '0;
      iss_op_q <= '0;
      res_valid_q <= 1'b0;
      res_src_q <= 1'b0;
      res_tag_q <= '0;
      res_q <= '0;
    end else begin
      iss_v_q <= iss_v_d;
      iss_src_q <= iss_src_d;
      iss_tag_q <= iss_tag_d;
      iss_op_q <= iss_op_d;
      res_valid_q <= res_valid_d;
      res_src_q <= res_src_d;
      res_tag_q <= res_tag_d;
      res_q <= res_d;
    end
  end
  assign {n_s, n_final_m, n_h_s, n_exp, n_frac} = iss_op_q;
  assign {res_s, res_exp, res_frac, res_zero, res_denorm} = res_q;
  assign res_valid = res_valid_q;
  assign res_src = res_src_q;
  assign res_tag = res_tag_q;
  assign busy = iss_v_q | res_valid_q;
endmodule

// File: doc/norm_arbiter.md
Name: norm_arbiter

Overview:
- Shares one normalization datapath (sign fix, leading-zero shift, exponent adjust, sticky) between two requesters: A = multiply/FMA path, B = add/sub path.
- Round-robin arbitration with valid/ready handshakes on both requesters.
- Two-stage registered pipeline: an issue register drives the shared datapath; a result register captures its outputs.
- A single tagged result port carries source ID and supports backpressure.

Parameters:
TAG_W, 4, width of the requester transaction tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all in-flight operations.
- a_valid  in  1  requester A has an operation.
- a_ready  out  1  requester A's operation is accepted this cycle.
- a_s, a_final_m, a_h_s  in  1 each  requester A's sign inputs: s_tmp, final_m and frac_inter_h_s.
- a_exp  in  10  requester A's exp_tmp.
- a_frac  in  75  requester A's frac_inter.
- a_tag  in  TAG_W  requester A's tag.
- b_*  same set of ports as a_*, for requester B.
- n_s, n_final_m, n_h_s, n_exp, n_frac  out  1/1/1/10/75  issue-register fields driven to the shared datapath.
- n_s_final  in  1  datapath result: final sign.
- n_exp_norm  in  10  datapath result: normalized exponent.
- n_frac_norm  in  27  datapath result: normalized fraction.
- n_zero_m  in  1  datapath result: zero mask.
- n_denorm_m  in  1  datapath result: denormal mask.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_src  out  1  result source: 0 = A, 1 = B.
- res_tag  out  TAG_W  result tag.
- res_s  out  1  registered s_final.
- res_exp  out  10  registered exp_norm.
- res_frac  out  27  registered frac_inter_norm.
- res_zero  out  1  registered zero mask.
- res_denorm  out  1  registered denorm mask.
- busy  out  1  iss_v OR res_valid.

Behaviour:
- Reset (async): iss_v=0, res_valid=0, rr_ptr=0 (A has priority). All data registers reset to 0, so n_* = 0 and res_* = 0. a_ready and b_ready are combinational and read 0 during reset.
- Pipeline enables:
  - res_en = !res_valid | res_ready.
  - iss_en = !iss_v | res_en.
- Arbitration (combinational):
  - Only one requester valid: it wins.
  - Both valid: winner = A if rr_ptr=0, else B.
  - a_ready = iss_en & !flush & winner==A; b_ready likewise for B. The loser's ready is 0.
- Accept: on a_ready&a_valid (or B), the issue register loads payload, tag and src.
  - iss_v is set when an accept occurs.
  - Otherwise, if res_en, iss_v is cleared.
  - rr_ptr toggles only when both requesters were valid and a grant occurred; it then points to the loser. A sole requester never moves rr_ptr.
- Issue stage: n_* are driven directly from the issue register. The datapath is combinational, so its results are valid in the same cycle.
- Result stage: when res_en, the result register loads (n_s_final, n_exp_norm, n_frac_norm, n_zero_m, n_denorm_m, iss_tag, iss_src) and res_valid <= iss_v.
- Latency: accept at cycle T → res_valid at T+2 with no backpressure.
- Throughput: one operation per cycle.
- Backpressure: while res_valid & !res_ready, the result register holds and all res_* fields stay stable.
  - An occupied issue register also holds; a_ready = b_ready = 0.
  - An empty issue register may still accept one operation.
- Simultaneous accept and drain: when res_ready=1 with both stages full and a requester valid, all three actions happen in one cycle (result retires, issue moves to result, new operation issues). No bubble.
- Flush (sync): next edge iss_v=0, res_valid=0. Ready is forced to 0 in the flush cycle, so nothing is accepted. rr_ptr is unchanged. Flush has priority over every other update.
- Reset mid-operation: all in-flight operations are lost; no result is emitted for them.
- Data fields are not qualified: the datapath sees stale n_* when iss_v=0. This is harmless, because the result register's valid bit gates it.
- Requester rule: requesters hold their payload stable while valid & !ready. The block does not check this.

Decomposition:
- Shared package/include norm_defs.vh holds the constants:
  - EXP_W=10, FRAC_IN_W=75, FRAC_OUT_W=27.
  - SRC_A=1'b0, SRC_B=1'b1.
- One natural sub-module: rr_arb2 (two-way round-robin arbiter, with rr_ptr register, grant and toggle logic).
- Pipeline registers stay in norm_arbiter.
- The norm_stage instance stays outside this block; it is wired through the n_* ports at the next level up.

Test Plan:
1. Single op: a_valid=1 for one cycle, a_exp=10'h07F, a_tag=3, res_ready=1 → a_ready=1 at T; res_valid=1 at T+2 with res_src=0, res_tag=3 and res_exp equal to the datapath model output; busy drops at T+3.
2. Contention: a_valid=b_valid=1 for 4 cycles, tags A=1, B=2, res_ready=1 → grants A,B,A,B; results arrive in the same order, each two cycles after its grant.
3. Backpressure: stream 3 ops from B, with res_ready=0 from the cycle the first result appears → res_* stays stable; b_ready=0 after the issue register fills; on res_ready=1, all 3 results drain in order with no loss or duplication.
4. Full-pipe simultaneous: both stages full, res_ready=1, a_valid=1 → retire, advance and accept occur in the same cycle; res_valid stays continuously high.
5. Flush: 2 ops in flight, flush pulse for 1 cycle with a_valid=1 → res_valid=0 and iss_v=0 after the edge; a_ready=0 during the flush cycle; the next accepted op emerges normally.
6. Async reset: assert rst mid-stream, asynchronously to clk → res_valid and busy go to 0 immediately; rr_ptr=0; after release, the first contention grants A.
